pwm_speed_sequencer: RTL and testbench

Upstream control stage for the configurable PWM generator. It converts two raw push-buttons and a run request into the `enable` and 3-bit `speed` command that the PWM stage consumes. Button presses are synchronised and debounced, and the target speed saturates at 0 and 7. The applied speed ramps one step at a time toward the target (soft start and soft stop), so the PWM duty never jumps.

---
 rtl/pwm_speed_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pwm_speed_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_speed_sequencer.sv
// Button/run-request front end for the PWM stage: synchronises and debounces the
// buttons, keeps a saturating target speed, and ramps the applied speed toward it.
module pwm_speed_sequencer #(
    parameter int DB_CYCLES   = 1000,
    parameter int RAMP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       run_req,
    output logic [2:0] speed,
    output logic       enable,
    output logic [2:0] target,
    output logic       busy
);

    localparam int DB_W = $clog2(DB_CYCLES) + 1;
    localparam int RP_W = $clog2(RAMP_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD, S_STOP} state_t;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]      w_btn_raw;
    logic [1:0]      r_btn_m;
    logic [1:0]      r_btn_s;
    logic            r_run_m;
    logic            r_run_s;
    logic [1:0]      r_btn_lvl;
    logic [1:0]      r_btn_press;
    logic [DB_W-1:0] r_btn_cnt [2];
    logic [2:0]      r_target;
    state_t          r_state;
    logic [RP_W-1:0] r_timer;
    logic [2:0]      r_speed;
    logic            r_enable;
    logic            r_busy;
    logic            w_step;

    assign w_btn_raw = {btn_dn, btn_up};
    assign w_step    = (r_timer == RP_W'(RAMP_CYCLES - 1));

    assign speed  = r_speed;
    assign enable = r_enable;
    assign target = r_target;
    assign busy   = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_m <= '0;
            r_btn_s <= '0;
            r_run_m <= 1'b0;
            r_run_s <= 1'b0;
        end else begin
            r_btn_m <= w_btn_raw;
            r_btn_s <= r_btn_m;
            r_run_m <= run_req;
            r_run_s <= r_run_m;
        end
    end

    // A press is flagged in the same cycle the stable level rises; release is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_lvl   <= '0;
            r_btn_press <= '0;
            for (int i = 0; i < 2; i++) r_btn_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_btn_press[i] <= 1'b0;
                if (r_btn_s[i] == r_btn_lvl[i]) begin
                    r_btn_cnt[i] <= '0;
                end else if (r_btn_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    r_btn_lvl[i]   <= r_btn_s[i];
                    r_btn_press[i] <= r_btn_s[i];
                    r_btn_cnt[i]   <= '0;
                end else begin
                    r_btn_cnt[i] <= r_btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= 3'd0;
        end else if (r_btn_press == 2'b01 && r_target != 3'd7) begin
            r_target <= r_target + 3'd1;
        end else if (r_btn_press == 2'b10 && r_target != 3'd0) begin
            r_target <= r_target - 3'd1;
        end
    end

    // Timer runs only in TRACK/STOP and is zeroed on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_speed  <= 3'd0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_speed <= 3'd0;
                    r_timer <= '0;
                    if (r_run_s) begin
                        r_state  <= S_TRACK;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (!r_run_s) begin
                        r_state <= S_STOP;
                        r_timer <= '0;
                    end else if (r_speed == r_target) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                    end else if (w_step) begin
                        r_timer <= '0;
                        r_speed <= (r_speed < r_target) ? r_speed + 3'd1 : r_speed - 3'd1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    r_timer <= '0;
                    if (!r_run_s) begin
                        r_state <= S_STOP;
                        r_busy  <= 1'b1;
                    end else if (r_target != r_speed) begin
                        r_state <= S_TRACK;
                        r_busy  <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_run_s) begin
                        r_state <= S_TRACK;
                        r_timer <= '0;
                    end else if (r_speed == 3'd0) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                        r_timer  <= '0;
                    end else if (w_step) begin
                        r_speed <= r_speed - 3'd1;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_speed_sequencer.sv
// Scoreboard bench: each expected output change {enable,busy,target,speed} is queued
// with its required cycle or spacing, and popped when the outputs actually change.
module tb_pwm_speed_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       run_req;
    logic [2:0] speed;
    logic       enable;
    logic [2:0] target;
    logic       busy;

    pwm_speed_sequencer #(.DB_CYCLES(4), .RAMP_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .run_req(run_req),
        .speed(speed), .enable(enable), .target(target), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         at;
        int         dt;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_on = 1'b0;
    logic [7:0] cur_val;
    logic [7:0] last_val;
    int         last_cyc = 0;
    int         d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // at: absolute cycle of the change (-1 = free); dt: cycles since previous change (-1 = free)
    function automatic void push(input logic en, input logic bsy, input logic [2:0] tgt,
                                 input logic [2:0] spd, input int at, input int dt);
        exp_t e;
        e.val = {en, bsy, tgt, spd};
        e.at  = at;
        e.dt  = dt;
        sb.push_back(e);
    endfunction

    function automatic void push_step_group(input int k, input int from_spd);
        push(1'b1, 1'b0, 3'(k), 3'(from_spd), -1, -1);
        push(1'b1, 1'b1, 3'(k), 3'(from_spd), -1, 1);
        push(1'b1, 1'b1, 3'(k), 3'(k), -1, 8);
        push(1'b1, 1'b0, 3'(k), 3'(k), -1, 1);
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            cur_val = {enable, busy, target, speed};
            if (cur_val !== last_val) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_change", cur_val, last_val);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("out_change", cur_val, mon_e.val);
                    if (mon_e.at >= 0) check_val("change_cycle", cyc, mon_e.at);
                    if (mon_e.dt >= 0) check_val("change_spacing", cyc - last_cyc, mon_e.dt);
                end
                last_val = cur_val;
                last_cyc = cyc;
            end
        end
    end

    task automatic press(input logic up, input logic dn, input int hold, input int gap);
        btn_up = up;
        btn_dn = dn;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int max);
        int i = 0;
        while (sb.size() != 0 && i < max) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_val("drain", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; run_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            btn_up  = 1'($urandom_range(0, 1));
            btn_dn  = 1'($urandom_range(0, 1));
            run_req = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_val("rst_speed", speed, 0);
        check_val("rst_enable", enable, 0);
        check_val("rst_target", target, 0);
        check_val("rst_busy", busy, 0);
        btn_up = 1'b0; btn_dn = 1'b0; run_req = 1'b0;
        rst = 1'b0;
        last_val = {enable, busy, target, speed};
        last_cyc = cyc;
        mon_on = 1'b1;

        // Debounce: short glitch rejected, three long presses, simultaneous presses cancel
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(negedge clk);
        check_val("glitch_target", target, 0);
        for (int k = 1; k <= 3; k++) push(1'b0, 1'b0, 3'(k), 3'd0, -1, -1);
        for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 10, 10);
        drain(40);
        check_val("three_ups_target", target, 3);
        press(1'b1, 1'b1, 10, 10);
        check_val("both_target", target, 3);

        // Soft start to target 3
        d = cyc;
        push(1'b1, 1'b1, 3'd3, 3'd0, d + 3, -1);
        push(1'b1, 1'b1, 3'd3, 3'd1, d + 11, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 19, -1);
        push(1'b1, 1'b1, 3'd3, 3'd3, d + 27, -1);
        push(1'b1, 1'b0, 3'd3, 3'd3, d + 28, -1);
        run_req = 1'b1;
        drain(60);

        // Saturation upward and retarget while holding
        for (int k = 4; k <= 7; k++) push_step_group(k, k - 1);
        for (int k = 0; k < 9; k++) press(1'b1, 1'b0, 6, 6);
        drain(60);
        check_val("sat_up_target", target, 7);
        check_val("sat_up_speed", speed, 7);
        for (int k = 6; k >= 0; k--) push_step_group(k, k + 1);
        for (int k = 0; k < 9; k++) press(1'b0, 1'b1, 6, 6);
        drain(60);
        check_val("sat_dn_target", target, 0);
        check_val("sat_dn_enable", enable, 1);
        press(1'b0, 1'b1, 6, 6);
        check_val("dn_at_zero_target", target, 0);

        // Back up to 3, then soft stop
        for (int k = 1; k <= 3; k++) push_step_group(k, k - 1);
        for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 6, 6);
        drain(60);
        d = cyc;
        push(1'b1, 1'b1, 3'd3, 3'd3, d + 3, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 11, -1);
        push(1'b1, 1'b1, 3'd3, 3'd1, d + 19, -1);
        push(1'b1, 1'b1, 3'd3, 3'd0, d + 27, -1);
        push(1'b0, 1'b0, 3'd3, 3'd0, d + 28, -1);
        run_req = 1'b0;
        drain(60);
        d = cyc;
        push(1'b1, 1'b1, 3'd3, 3'd0, d + 3, -1);
        push(1'b1, 1'b1, 3'd3, 3'd1, d + 11, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 19, -1);
        push(1'b1, 1'b1, 3'd3, 3'd3, d + 27, -1);
        push(1'b1, 1'b0, 3'd3, 3'd3, d + 28, -1);
        run_req = 1'b1;
        drain(60);

        // Abort a stop at speed 1: enable never drops, ramp resumes with a fresh timer
        d = cyc;
        push(1'b1, 1'b1, 3'd3, 3'd3, d + 3, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 11, -1);
        push(1'b1, 1'b1, 3'd3, 3'd1, d + 19, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 31, -1);
        push(1'b1, 1'b1, 3'd3, 3'd3, d + 39, -1);
        push(1'b1, 1'b0, 3'd3, 3'd3, d + 40, -1);
        run_req = 1'b0;
        wait_cyc(d + 20);
        run_req = 1'b1;
        drain(60);

        // Full stop, restart, and reset in the middle of the ramp at speed 2
        d = cyc;
        push(1'b1, 1'b1, 3'd3, 3'd3, d + 3, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 11, -1);
        push(1'b1, 1'b1, 3'd3, 3'd1, d + 19, -1);
        push(1'b1, 1'b1, 3'd3, 3'd0, d + 27, -1);
        push(1'b0, 1'b0, 3'd3, 3'd0, d + 28, -1);
        run_req = 1'b0;
        drain(60);
        d = cyc;
        push(1'b1, 1'b1, 3'd3, 3'd0, d + 3, -1);
        push(1'b1, 1'b1, 3'd3, 3'd1, d + 11, -1);
        push(1'b1, 1'b1, 3'd3, 3'd2, d + 19, -1);
        push(1'b0, 1'b0, 3'd0, 3'd0, d + 21, -1);
        push(1'b1, 1'b1, 3'd0, 3'd0, d + 24, -1);
        push(1'b1, 1'b0, 3'd0, 3'd0, d + 25, -1);
        run_req = 1'b1;
        wait_cyc(d + 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drain(40);
        check_val("post_rst_target", target, 0);
        check_val("post_rst_speed", speed, 0);
        check_val("post_rst_enable", enable, 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
